// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for the async FIFO.
// Shares the FIFO memory write port among NREQ requesters.
// Priority is round-robin, and one requester may own the port for at most
// BURST consecutive beats.
// Grants are combinational so the memory captures wdata at the same edge.
module fifo_wr_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned BURST = 4,
  localparam int unsigned IW   = $clog2(NREQ),
  localparam int unsigned BW   = $clog2(BURST + 1),
  localparam int unsigned SW   = 16
) (
  input  logic                  w_clk,
  input  logic                  w_rst_n,
  input  logic                  arb_en,
  input  logic                  full,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  wr_rq,
  output logic [WIDTH-1:0]      wdata,
  output logic [IW-1:0]         owner,
  output logic                  busy,
  output logic [SW-1:0]         stall_cnt
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  logic [0:0]    st_q,     st_d;
  logic [IW-1:0] ptr_q,    ptr_d;
  logic [IW-1:0] owner_q,  owner_d;
  logic [BW-1:0] beats_q,  beats_d;
  logic [SW-1:0] stall_q,  stall_d;

  logic [IW-1:0] srch_start;
  logic          srch_hit;
  logic [IW-1:0] srch_win;
  logic          grant;
  logic          grant_ok;
  logic [IW-1:0] gidx;
  logic          stall_cycle;

  // Next index with wrap to 0 after NREQ-1 (also covers non-power-of-2 NREQ).
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    if (i == IW'(NREQ - 1)) begin
      return '0;
    end
    return i + IW'(1);
  endfunction

  // Search starts at ptr when idle, just past the owner when an owner releases.
  always_comb begin
    srch_start = (st_q == ST_OWNED) ? wrap_inc(owner_q) : ptr_q;
  end

  // Round-robin search: the lowest distance from srch_start wins.
  always_comb begin
    logic [IW-1:0] idx;
    srch_hit = 1'b0;
    srch_win = '0;
    idx      = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      idx = IW'((int'(srch_start) + k) % int'(NREQ));
      if (req[idx]) begin
        srch_hit = 1'b1;
        srch_win = idx;
      end
    end
  end

  // Next-state and grant decision.
  always_comb begin
    st_d    = st_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    beats_d = beats_q;
    grant   = 1'b0;
    gidx    = owner_q;

    if (!arb_en) begin
      // Disabled: no grant, drop ownership, rotate past an interrupted owner.
      st_d    = ST_IDLE;
      beats_d = '0;
      if (st_q == ST_OWNED) begin
        ptr_d = wrap_inc(owner_q);
      end
    end else if (st_q == ST_OWNED && req[owner_q]) begin
      // Owner still requesting: keep the port, unless full stalls the beat.
      if (!full) begin
        grant = 1'b1;
        gidx  = owner_q;
        if (beats_q + BW'(1) == BW'(BURST)) begin
          st_d    = ST_IDLE;
          ptr_d   = wrap_inc(owner_q);
          beats_d = '0;
        end else begin
          beats_d = beats_q + BW'(1);
        end
      end
    end else begin
      // Idle, or owner released: arbitrate among the remaining requesters now.
      if (!full && srch_hit) begin
        grant = 1'b1;
        gidx  = srch_win;
        if (BURST == 1) begin
          st_d    = ST_IDLE;
          ptr_d   = wrap_inc(srch_win);
          beats_d = '0;
        end else begin
          st_d    = ST_OWNED;
          owner_d = srch_win;
          beats_d = BW'(1);
        end
      end else if (st_q == ST_OWNED) begin
        st_d    = ST_IDLE;
        ptr_d   = wrap_inc(owner_q);
        beats_d = '0;
      end
    end
  end

  // Saturating count of cycles where a request is blocked by full.
  always_comb begin
    stall_cycle = arb_en & (|req) & full;
    stall_d     = stall_q;
    if (stall_cycle && stall_q != {SW{1'b1}}) begin
      stall_d = stall_q + SW'(1);
    end
  end

  // State registers.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      st_q    <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      beats_q <= '0;
      stall_q <= '0;
    end else begin
      st_q    <= st_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      beats_q <= beats_d;
      stall_q <= stall_d;
    end
  end

  // Grant gated by reset so outputs clear the instant reset asserts.
  always_comb begin
    grant_ok = grant & w_rst_n;
    gnt      = grant_ok ? (NREQ'(1) << gidx) : '0;
    wr_rq    = grant_ok;
  end

  // AND-OR data mux over the one-hot grant; zero when nothing is granted.
  always_comb begin
    wdata = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt[i]) begin
        wdata = wdata | req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Status outputs straight from state.
  always_comb begin
    owner     = owner_q;
    busy      = (st_q == ST_OWNED);
    stall_cnt = stall_q;
  end

endmodule
